// File: rtl/imm_extend_unit.sv
// ----------------------------------------------------------------------------
// imm_extend_unit
//
// Purpose:
//   Registered immediate-extension stage with a valid/ready handshake on both
//   sides. The raw immediate is extended combinationally according to Mode
//   and then captured, so Output always comes straight from a flop.
//
//   Mode 00 : sign-extend
//   Mode 01 : zero-extend
//   Mode 10 : upper-immediate (Input in the top bOLD bits, low bits zero)
//   Mode 11 : branch offset (sign-extend, then shift left by 2)
//
// Configuration:
//   IMMEXT_SKID_EN  When defined, a second (skid) entry is added and InReady
//                   becomes a registered signal that drops only when both
//                   entries are full. When undefined, one entry is held and
//                   InReady = !OutValid || OutReady.
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Input     in   [bOLD-1:0] raw immediate
//   Mode      in   [1:0] extension mode, sampled with Input
//   InValid   in   upstream offers Input/Mode
//   InReady   out  block accepts this cycle
//   Flush     in   discard every held entry and any same-cycle input
//   Output    out  [bNEW-1:0] extended value
//   OutValid  out  Output is valid
//   OutReady  in   downstream consumes this cycle
// ----------------------------------------------------------------------------
module imm_extend_unit #(
    parameter int bOLD = 16,
    parameter int bNEW = 32   // must be >= bOLD + 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [bOLD-1:0] Input,
    input  logic [1:0]      Mode,
    input  logic            InValid,
    output logic            InReady,
    input  logic            Flush,
    output logic [bNEW-1:0] Output,
    output logic            OutValid,
    input  logic            OutReady
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    logic [bNEW-1:0] sext;
    logic [bNEW-1:0] ext;

    // NOTE: every variable written in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        sext = {{(bNEW-bOLD){Input[bOLD-1]}}, Input};
        ext  = sext;
        case (mode_e'(Mode))
            MODE_SEXT:   ext = sext;
            MODE_ZEXT:   ext = {{(bNEW-bOLD){1'b0}}, Input};
            MODE_UPPER:  ext = {Input, {(bNEW-bOLD){1'b0}}};
            MODE_BRANCH: ext = {sext[bNEW-3:0], 2'b00};
            default:     ext = sext;
        endcase
    end

    logic [bNEW-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            accept;
    logic            pop;

    assign pop = out_valid_q && OutReady;

`ifdef IMMEXT_SKID_EN

    logic [bNEW-1:0] skid_q, skid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;

    assign InReady = in_ready_q;
    assign accept  = InValid && in_ready_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (Flush) begin
            out_d        = '0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop) begin
            // Main entry is free this edge: the older skid entry moves up
            // first so acceptance order is preserved.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = ext;
                end
            end else if (accept) begin
                out_d       = ext;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main entry is stalled; park the new value in the skid entry.
            skid_d       = ext;
            skid_valid_d = 1'b1;
        end
        // Registered ready: the skid entry is the last free slot.
        in_ready_d = !skid_valid_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the data registers are reset too, so Output reads 0 during reset
    // and no stale value survives it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

`else

    assign InReady = !out_valid_q || OutReady;
    assign accept  = InValid && InReady;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (Flush) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            // Covers both an empty slot and a same-cycle replace on pop.
            out_d       = ext;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the data register is reset too, so Output reads 0 during reset
    // and no stale value survives it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

`endif

    assign Output   = out_q;
    assign OutValid = out_valid_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// ----------------------------------------------------------------------------
// tb_imm_extend_unit
//
// Scoreboard bench for imm_extend_unit (bOLD=16, bNEW=32). The driver pushes
// the expected extended value whenever a transfer in occurs; the monitor pops
// and compares whenever a transfer out occurs. Flush and reset empty the
// scoreboard, so any value that was discarded but still shows up is flagged.
// ----------------------------------------------------------------------------
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb[$];

    imm_extend_unit #(.bOLD(16), .bNEW(32)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Input    (in_data),
        .Mode     (in_mode),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .Flush    (flush),
        .Output   (out_data),
        .OutValid (out_valid),
        .OutReady (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: treat the immediate as a signed integer and apply the
    // mode's arithmetic meaning, then wrap to 32 bits.
    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        longint v;
        longint r;
        v = longint'(d);
        if (v >= 32768) v = v - 65536;
        case (m)
            2'd0:    r = v;
            2'd1:    r = longint'(d);
            2'd2:    r = longint'(d) * 65536;
            default: r = v * 4;
        endcase
        return r[31:0];
    endfunction

    // One clock of stimulus. Inputs change 1ns after the rising edge; the
    // handshake is evaluated once they have settled.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [1:0] m,
                         input logic ordy, input logic fl, input logic [31:0] exp,
                         output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = v && in_ready;
        if (fl) sb.delete();
        else if (acc) sb.push_back(exp);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 16'h0, 2'd0, ordy, 1'b0, 32'h0, acc);
    endtask

    // Monitor: compare on every transfer out, and confirm a stalled output
    // stays put until it is consumed.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_out  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_output", out_data, 32'hxxxxxxxx);
                    end else begin
                        check("sb_data", out_data, sb.pop_front());
                    end
                end
                prev_hold = out_valid && !out_ready && !flush;
                prev_out  = out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic        acc2;
        logic [31:0] exp_modes [4];
        logic [15:0] d;
        logic [1:0]  m;
        logic        v, ordy, fl;
        int          tries;

        exp_modes = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", out_data, 32'd0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", 32'(in_ready), 32'd1);

        // All four modes on 16'h8001, back to back, one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h8001, 2'(i), 1'b1, 1'b0, exp_modes[i], acc);
            check("mode_accept", 32'(acc), 32'd1);
            if (i > 0) begin
                check("mode_valid", 32'(out_valid), 32'd1);
                check("mode_data", out_data, exp_modes[i-1]);
            end
        end
        idle(1'b1);
        check("mode_valid", 32'(out_valid), 32'd1);
        check("mode_data", out_data, exp_modes[3]);
        idle(1'b1);

        // Back-pressure: 1 then 2 with downstream stalled.
        cycle(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0, 32'h00000001, acc);
        check("bp_accept1", 32'(acc), 32'd1);
        cycle(1'b1, 16'h0002, 2'd0, 1'b0, 1'b0, 32'h00000002, acc2);
`ifdef IMMEXT_SKID_EN
        check("bp_skid_accept2", 32'(acc2), 32'd1);
`endif
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            check("bp_hold_data", out_data, 32'h00000001);
`ifdef IMMEXT_SKID_EN
            check("bp_skid_full", 32'(in_ready), 32'd0);
`endif
        end
        tries = 0;
        while (!acc2 && tries < 10) begin
            cycle(1'b1, 16'h0002, 2'd0, 1'b1, 1'b0, 32'h00000002, acc2);
            tries++;
        end
        check("bp_accept2", 32'(acc2), 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Streaming: 0..7 with no bubbles in or out.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'(i), 2'd0, 1'b1, 1'b0, 32'(i), acc);
            check("stream_accept", 32'(acc), 32'd1);
            if (i > 0) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", out_data, 32'(i - 1));
            end
        end
        idle(1'b1);
        check("stream_data", out_data, 32'd7);
        idle(1'b1);

        // Flush with held entries plus a same-cycle offer.
        cycle(1'b1, 16'h00AA, 2'd1, 1'b0, 1'b0, 32'h000000AA, acc);
        cycle(1'b1, 16'h00BB, 2'd1, 1'b0, 1'b0, 32'h000000BB, acc);
        cycle(1'b1, 16'h00CC, 2'd1, 1'b0, 1'b1, 32'h000000CC, acc);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("flush_valid", 32'(out_valid), 32'd0);
            check("flush_ready", 32'(in_ready), 32'd1);
        end

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h1230 + i), 2'd0, 1'b1, 1'b0, 32'(16'h1230 + i), acc);
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", out_data, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        #6;
        rst = 1'b0;
        idle(1'b1);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_idle", 32'(out_valid), 32'd0);
        idle(1'b1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 99) < 70);
            d    = 16'($urandom);
            m    = 2'($urandom_range(0, 3));
            fl   = ($urandom_range(0, 99) < 3);
            ordy = fl ? 1'b0 : ($urandom_range(0, 99) < 65);
            cycle(v, d, m, ordy, fl, model(d, m), acc);
        end
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter bOLD, default 16, giving the input immediate width.
REQ-002 The block SHALL have parameter bNEW, default 32, giving the output width; bNEW >= bOLD+2.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port Input, input, bOLD, the raw immediate.
REQ-006 The block SHALL have port Mode, input, 2, the extension mode sampled with Input.
REQ-007 The block SHALL have port InValid, input, 1, meaning upstream offers Input/Mode this cycle.
REQ-008 The block SHALL have port InReady, output, 1, meaning the block accepts this cycle.
REQ-009 The block SHALL have port Flush, input, 1, which discards all held entries.
REQ-010 The block SHALL have port Output, output, bNEW, the extended value.
REQ-011 The block SHALL have port OutValid, output, 1, meaning Output is valid.
REQ-012 The block SHALL have port OutReady, input, 1, meaning downstream consumes this cycle.

Function
REQ-013 Mode 00 SHALL sign-extend: upper bNEW-bOLD bits copy Input[bOLD-1].
REQ-014 Mode 01 SHALL zero-extend: upper bNEW-bOLD bits are 0.
REQ-015 Mode 10 SHALL place Input in Output[bNEW-1:bNEW-bOLD], lower bits 0 (upper-immediate load).
REQ-016 Mode 11 SHALL sign-extend then shift left by 2, bits shifted out discarded (branch offset).
REQ-017 Transfer in SHALL occur when InValid && InReady; transfer out when OutValid && OutReady.
REQ-018 Latency SHALL be one cycle: a value accepted at edge N is on Output with OutValid high after edge N.
REQ-019 Extension SHALL be computed before the register; Output SHALL be driven directly from a register.
REQ-020 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-021 Output and OutValid SHALL hold stable while OutValid && !OutReady.
REQ-022 Simultaneous in and out transfer SHALL replace the departing entry with the arriving one without a bubble.
REQ-023 Flush SHALL, at the next edge, clear all entries and deassert OutValid; a same-cycle input transfer is discarded.
REQ-024 Flush SHALL override OutReady; InReady SHALL be 1 in the cycle after Flush.

Reset
REQ-025 Reset SHALL asynchronously force OutValid=0, Output=0, all internal entries empty.
REQ-026 InReady SHALL be 1 in the first cycle after Reset deasserts.
REQ-027 Reset asserted mid-transfer SHALL discard the in-flight entry; it SHALL not reappear after release.

Configuration
REQ-028 With IMMEXT_SKID_EN defined, a second (skid) entry SHALL exist and InReady SHALL be a registered signal, deasserting only when both entries are full.
REQ-029 With IMMEXT_SKID_EN defined, an entry accepted while OutValid && !OutReady SHALL be held in the skid entry and presented after the current one leaves.
REQ-030 Without IMMEXT_SKID_EN, one entry SHALL exist and InReady SHALL equal !OutValid || OutReady combinationally.
REQ-031 Functional results (values, order) SHALL be identical with and without the macro; only back-pressure timing differs.

Verification
REQ-032 Mode 00, Input=16'h8001, OutReady=1 -> Output=32'hFFFF8001 one cycle later, OutValid=1.
REQ-033 Modes 01/10/11 with Input=16'h8001 -> 32'h00008001 / 32'h80010000 / 32'hFFFE0004.
REQ-034 Back-pressure: OutReady=0, inputs 16'h0001 then 16'h0002 -> Output holds 32'h00000001; skid build: InReady=0 after second accept; release OutReady -> 1 then 2 in order, no loss.
REQ-035 Streaming: InValid=OutReady=1 for 8 cycles, Input=0..7, Mode 00 -> Output=0..7 on consecutive cycles, no bubbles.
REQ-036 Flush with two entries held and InValid=1 -> next cycle OutValid=0, InReady=1, none of the three values ever appear.
REQ-037 Reset pulse mid-stream, asynchronous to Clk -> OutValid=0, Output=0 immediately; after release, InReady=1, stale values never output.
